// File: rtl/mips_cpu_lsu_if.sv
// Avalon-MM bus between the load/store unit (master) and the memory fabric (slave).
interface mips_cpu_lsu_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one MEMORY-stage operation per start pulse over Avalon-MM,
// with store lane replication and sign/zero-extended or LWL/LWR-merged loads.
module mips_cpu_lsu #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [31:0]    addr,
    input  logic [31:0]    store_data,
    input  logic [31:0]    rt_old,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [31:0]    load_result,
    mips_cpu_lsu_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              is_load_c, is_store_c, is_half_c, is_word_c, req_err_c;
    logic [1:0]        lane_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wd_c;
    logic [4:0]        shamt_c;
    logic [DATA_W-1:0] shifted_c, load_c;

    // Request decode; forcing low lane bits only matters when misalignment is not trapped.
    always_comb begin
        is_load_c  = (op <= OP_LWR);
        is_store_c = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        is_half_c  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        is_word_c  = (op == OP_LW) || (op == OP_SW);
        lane_c     = addr[1:0];
        if (is_half_c) begin
            lane_c[0] = 1'b0;
        end
        if (is_word_c) begin
            lane_c = 2'b00;
        end
        req_err_c = !(is_load_c || is_store_c)
                  || (ALIGN_CHECK && ((is_half_c && addr[0]) || (is_word_c && (addr[1:0] != 2'b00))));
        be_c = 4'b1111;
        wd_c = store_data;
        case (op)
            OP_SB: begin
                be_c = 4'(4'b0001 << lane_c);
                wd_c = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be_c = lane_c[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and LWL/LWR merge from the captured readdata.
    always_comb begin
        shamt_c   = {lane_q, 3'b000};
        shifted_c = bus.readdata >> shamt_c;
        case (op_q)
            OP_LB:   load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            OP_LBU:  load_c = {24'h0, shifted_c[7:0]};
            OP_LH:   load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            OP_LHU:  load_c = {16'h0, shifted_c[15:0]};
            OP_LWL:  load_c = (bus.readdata << {~lane_q, 3'b000})
                            | (rt_q & (32'h00FF_FFFF >> shamt_c));
            OP_LWR:  load_c = shifted_c | (rt_q & ~(32'hFFFF_FFFF >> shamt_c));
            default: load_c = bus.readdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        lane_d   = lane_q;
        rt_d     = rt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        result_d = result_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_err_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        op_d    = op;
                        lane_d  = lane_c;
                        rt_d    = rt_old;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_c;
                        wd_d    = wd_c;
                        read_d  = is_load_c;
                        write_d = is_store_c;
                    end
                end
            end
            S_REQ: begin
                if (bus.waitrequest) begin
                    read_d  = read_q;
                    write_d = write_q;
                end else if (write_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                result_d = load_c;
                state_d  = S_DONE;
                done_d   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            lane_q   <= '0;
            rt_q     <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            rt_q     <= rt_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            read_q   <= read_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign load_result    = result_q;
    assign bus.address    = addr_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = wd_q;
    assign bus.byteenable = be_q;
endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu: byte-level reference model, Avalon slave
// with random stalls, separate completion and bus monitors.
module tb_mips_cpu_lsu;
    typedef struct packed {
        logic        err;
        logic        is_load;
        logic        is_store;
        logic [31:0] res;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] t_done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr, store_data, rt_old;
    logic        busy, done, error;
    logic [31:0] load_result;

    mips_cpu_lsu_if bus ();

    mips_cpu_lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .addr        (addr),
        .store_data  (store_data),
        .rt_old      (rt_old),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .load_result (load_result),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t bq[$];
    int   done_seen = 0;
    int   seen_base = 0;

    // Stimulus-side controls for the slave
    logic [31:0] rd_word = 32'h0;
    int          op_id = 0;
    int          stall_budget = 0;
    bit          hold_wait = 1'b0;
    bit          rand_stalls = 1'b0;

    // Slave-side state
    int   last_id = 0;
    int   stall_used = 0;
    int   stall_cnt = 0;
    bit   rd_pending = 1'b0;
    logic wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: works on individual bytes of the memory word and rt.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] ad, sd, rt, mw);
        exp_t       e;
        logic [7:0] mb [4];
        logic [7:0] ob [4];
        logic [15:0] h;
        int         a;
        e      = '0;
        a      = int'(ad[1:0]);
        e.addr = {ad[31:2], 2'b00};
        e.be   = 4'hF;
        for (int i = 0; i < 4; i++) begin
            mb[i] = mw[8*i +: 8];
            ob[i] = rt[8*i +: 8];
        end
        case (o)
            4'd0, 4'd1: begin
                e.is_load = 1'b1;
                e.res = {24'h0, mb[a]};
                if (o == 4'd0 && mb[a][7]) e.res[31:8] = '1;
            end
            4'd2, 4'd3: begin
                if (a % 2 != 0) e.err = 1'b1;
                else begin
                    e.is_load = 1'b1;
                    h = {mb[a+1], mb[a]};
                    e.res = {16'h0, h};
                    if (o == 4'd2 && h[15]) e.res[31:16] = '1;
                end
            end
            4'd4: begin
                if (a != 0) e.err = 1'b1;
                else begin e.is_load = 1'b1; e.res = mw; end
            end
            4'd5: begin
                e.is_load = 1'b1;
                for (int i = 0; i < 4; i++) if (i >= 3 - a) ob[i] = mb[i-(3-a)];
                e.res = {ob[3], ob[2], ob[1], ob[0]};
            end
            4'd6: begin
                e.is_load = 1'b1;
                for (int i = 0; i < 4; i++) if (i + a <= 3) ob[i] = mb[i+a];
                e.res = {ob[3], ob[2], ob[1], ob[0]};
            end
            4'd8: begin
                e.is_store = 1'b1;
                e.be = 4'h0;
                e.be[a] = 1'b1;
                for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = sd[7:0];
            end
            4'd9: begin
                if (a % 2 != 0) e.err = 1'b1;
                else begin
                    e.is_store = 1'b1;
                    e.be = 4'h0;
                    e.be[a] = 1'b1;
                    e.be[a+1] = 1'b1;
                    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = (i % 2 == 0) ? sd[7:0] : sd[15:8];
                end
            end
            4'd10: begin
                if (a != 0) e.err = 1'b1;
                else begin e.is_store = 1'b1; e.wd = sd; end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Avalon slave: waitrequest policy and readdata only valid the cycle after a read is accepted.
    always @(negedge clk) begin
        if (op_id != last_id) begin
            last_id    = op_id;
            stall_used = 0;
            stall_cnt  = 0;
        end
        bus.readdata = rd_pending ? rd_word : $urandom;
        rd_pending   = 1'b0;
        if (bus.read || bus.write) begin
            if (hold_wait) wr = 1'b1;
            else if (stall_used < stall_budget) begin wr = 1'b1; stall_used++; end
            else wr = rand_stalls && ($urandom_range(0, 3) == 0);
            if (wr) stall_cnt++;
            else rd_pending = bus.read;
        end else begin
            wr = 1'($urandom_range(0, 1));
        end
        bus.waitrequest = wr;
    end

    // Completion monitor
    exp_t m;
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                m = exp_q.pop_front();
                check("error", 32'(error), 32'(m.err));
                check("done_cycle", cyc, m.t_done + 32'(stall_cnt));
                check("busy_at_done", 32'(busy), 32'd1);
                if (m.is_load && !m.err) check("load_result", load_result, m.res);
            end
        end
    end

    // Bus monitor: every request cycle must match the pending op; pop when the request drops.
    exp_t b;
    bit   prev_req = 1'b0;
    bit   req;
    always @(negedge clk) begin
        req = bus.read || bus.write;
        if (req) begin
            if (bus.read && bus.write) begin
                vectors++;
                miscompares++;
                $display("FAIL read_and_write: got both high expected one (cycle %0d)", cyc);
            end
            if (bq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL bus_unexpected: got read=%0b write=%0b expected idle bus", bus.read, bus.write);
            end else begin
                b = bq[0];
                check("bus_address", bus.address, b.addr);
                check("bus_byteenable", 32'(bus.byteenable), 32'(b.be));
                check("bus_read", 32'(bus.read), 32'(b.is_load));
                check("bus_write", 32'(bus.write), 32'(b.is_store));
                if (b.is_store) check("bus_writedata", bus.writedata, b.wd);
            end
        end else if (prev_req && bq.size() != 0) begin
            void'(bq.pop_front());
        end
        prev_req = req;
    end

    task automatic issue_op(input logic [3:0] o, input logic [31:0] ad, sd, rt, mw,
                            input int stalls, input bit extra);
        exp_t e;
        e = model(o, ad, sd, rt, mw);
        @(posedge clk); #1;
        start        = 1'b1;
        op           = o;
        addr         = ad;
        store_data   = sd;
        rt_old       = rt;
        rd_word      = mw;
        stall_budget = stalls;
        op_id++;
        e.t_done = cyc + (e.err ? 32'd1 : (e.is_load ? 32'd3 : 32'd2));
        exp_q.push_back(e);
        if (!e.err) bq.push_back(e);
        seen_base = done_seen;
        @(posedge clk); #1;
        if (extra) begin
            op = 4'($urandom); addr = $urandom; store_data = $urandom; rt_old = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        op = 4'($urandom); addr = $urandom; store_data = $urandom; rt_old = $urandom;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_seen == seen_base && k < 64) begin
            @(posedge clk);
            k++;
        end
        check("completion_seen", 32'(done_seen != seen_base), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_pulse_width", 32'(done), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] ad, sd, rt, mw,
                          input int stalls, input bit extra);
        issue_op(o, ad, sd, rt, mw, stalls, extra);
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_read"}, 32'(bus.read), 32'd0);
        check({tag, "_write"}, 32'(bus.write), 32'd0);
        check({tag, "_load_result"}, load_result, 32'd0);
        check({tag, "_address"}, bus.address, 32'd0);
        check({tag, "_byteenable"}, 32'(bus.byteenable), 32'd0);
        check({tag, "_writedata"}, bus.writedata, 32'd0);
    endtask

    logic [3:0] legal_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    logic [3:0] bad_ops [6]    = '{4'd7, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; addr = 32'd0; store_data = 32'd0; rt_old = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        run_op(4'd10, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b0);
        run_op(4'd0,  32'h0000_2003, 32'h0, 32'h0, 32'h80FF_1234, 2, 1'b0);
        run_op(4'd9,  32'h0000_3002, 32'h0000_ABCD, 32'h0, 32'h0, 0, 1'b0);
        run_op(4'd3,  32'h0000_3002, 32'h0, 32'h0, 32'hABCD_0000, 0, 1'b0);
        run_op(4'd4,  32'h0000_4001, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        run_op(4'd7,  32'h0000_4000, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        run_op(4'd5,  32'h0000_5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
        run_op(4'd6,  32'h0000_5001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b1);

        // Reset while a read is stalled in the request phase
        hold_wait = 1'b1;
        issue_op(4'd4, 32'h0000_6000, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
        @(negedge clk);
        check("pre_reset_read", 32'(bus.read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_read", 32'(bus.read), 32'd0);
        check("abort_write", 32'(bus.write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        hold_wait = 1'b0;
        exp_q.delete();
        bq.delete();
        run_op(4'd4, 32'h0000_6000, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);

        rand_stalls = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [3:0] o;
            if ($urandom_range(0, 7) == 0) o = bad_ops[$urandom_range(0, 5)];
            else o = legal_ops[$urandom_range(0, 9)];
            run_op(o, $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
